pooling_layer_sequencer: RTL and testbench
==========================================

# pooling_layer_sequencer

Frame-level controller for `pooling_layer`. It accepts a pixel stream from the upstream layer over a valid/ready handshake and drives the pooling layer's `clk_en` and `input_data`. Pooled pixels pass to the downstream layer through a 2-entry skid buffer. The block counts input and output pixels, flushes the pooling pipeline at end of frame and reports frame completion or a count error.

## Interface
- `D_WIDTH`, 8, bits per channel
- `CHANNELS`, 3, channels per pixel
- `IMAGE_WIDTH`, 64, input frame width in pixels
- `IMAGE_HEIGHT`, 32, input frame height in pixels
- `STRIDE`, 2, pooling stride; expected outputs = `IMAGE_WIDTH*IMAGE_HEIGHT/STRIDE**2`
- `FLUSH_CYCLES`, 4, enabled pool cycles issued after the last input pixel
- `DRAIN_TIMEOUT`, 64, cycles allowed in DRAIN before an error is flagged
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse; begins a frame, ignored unless IDLE
- `src_data`  in  `D_WIDTH*CHANNELS`  upstream pixel
- `src_valid`  in  1  upstream pixel available
- `src_ready`  out  1  pixel accepted this cycle when `src_valid && src_ready`
- `pool_clk_en`  out  1  to `pooling_layer.clk_en`
- `pool_data`  out  `D_WIDTH*CHANNELS`  to `pooling_layer.input_data`
- `pool_out_data`  in  `D_WIDTH*CHANNELS`  from `pooling_layer.output_data`
- `pool_valid`  in  1  from `pooling_layer.valid`
- `dst_data`  out  `D_WIDTH*CHANNELS`  pooled pixel
- `dst_valid`  out  1  pooled pixel available
- `dst_ready`  in  1  downstream accepts
- `busy`  out  1  high in any state other than IDLE
- `frame_done`  out  1  one-cycle pulse at successful frame end
- `count_error`  out  1  sticky until next `start` or reset

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE → STREAM on `start`. The transition clears the input count, output count and `count_error`.
- In STREAM:
  - `pool_clk_en = src_valid && skid_free >= 1`, where `skid_free` is the number of free skid entries after this cycle's dequeue.
  - `src_ready = pool_clk_en`.
  - `pool_data = src_data`, combinational pass-through.
- STREAM → DRAIN in the cycle the last input pixel is accepted, i.e. input count reaches `IMAGE_WIDTH*IMAGE_HEIGHT`.
- In DRAIN:
  - `src_ready = 0`.
  - `pool_data = 0`.
  - `pool_clk_en` is asserted, gated by skid space, until `FLUSH_CYCLES` enabled cycles have been issued.
- DRAIN → DONE when the output count equals the expected count and the skid buffer is empty.
- DRAIN → DONE with `count_error = 1` when `DRAIN_TIMEOUT` cycles elapse in DRAIN.
- DONE lasts exactly one cycle and pulses `frame_done` only when there is no error. DONE → IDLE.
- A `pool_valid` pulse is captured into the skid buffer and increments the output count.
- A `pool_valid` that would exceed the expected output count sets `count_error`. The data is still forwarded.
- Counter widths are `$clog2(total+1)`. Counters saturate and never wrap.
- A `pool_valid` while the skid buffer is full cannot occur by construction. If it does, it sets `count_error` and the data is dropped.
- Simultaneous enqueue and dequeue in the same cycle is legal at any occupancy.

## Timing
- Reset values:
  - `src_ready = 0`, `pool_clk_en = 0`, `pool_data = 0`
  - `dst_valid = 0`, `dst_data = 0`
  - `busy = 0`, `frame_done = 0`, `count_error = 0`
  - state IDLE, skid buffer empty
- Reset asserted mid-frame aborts immediately to these values. No `frame_done` is produced.
- `start` is acted on in the cycle it is sampled. The first `src_ready` can be high in the following cycle.
- Skid buffer latency is 1 cycle: a `pool_valid` in cycle N gives `dst_valid` in cycle N+1.
- `dst_data` and `dst_valid` are registered outputs.
- `dst_data` is held stable while `dst_valid && !dst_ready`.
- `frame_done` appears no earlier than 1 cycle after the final `dst_valid && dst_ready` handshake.

## Configuration
- `POOL_SEQ_PERF_EN`
- Defined: adds a `stall_cycles` output, 32 bits wide. It counts STREAM cycles with `src_valid && !pool_clk_en` and clears on `start`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package (`definitions`):
  - state encoding, localparams `ST_IDLE`, `ST_STREAM`, `ST_DRAIN`, `ST_DONE`
  - the `PERIOD` macro already used by the benches
- Sub-module `pool_skid_buffer`:
  - 2-entry, parameterised by width
  - ports: `enq`, `enq_data`, `deq`, `free_count`, `out_valid`, `out_data`
- Expected-count arithmetic is a localparam computed inside the sequencer.

## Test plan
- Default parameters, 2048 pixels with `src_valid` and `dst_ready` held high → 512 `dst_valid` handshakes with data matching the reference output hex; `frame_done` pulses once; `count_error = 0`.
- `dst_ready` toggling 1-in-3 → no lost or duplicated pixels; `dst_data` is stable during stalls; `pool_clk_en` drops whenever the skid buffer is full.
- `src_valid` randomly low 50% of the time → `pool_clk_en` is never high while `src_valid` is low in STREAM; output matches the reference.
- Stub `pooling_layer` emits only 511 valids → after 64 DRAIN cycles, `count_error = 1`, no `frame_done`, return to IDLE.
- `rst_n` pulled low at input pixel 1000 and then released, followed by a fresh `start` → all outputs read their reset values; the next frame completes correctly with 512 outputs.
- With `POOL_SEQ_PERF_EN` defined, `src_valid` low for 10 STREAM cycles and `dst_ready` always high → `stall_cycles = 0`. With the skid buffer held full for 5 cycles while `src_valid` is high → `stall_cycles = 5`.

Source files
------------

// File: rtl/pooling_layer_sequencer_pkg.sv
// rtl/pooling_layer_sequencer_pkg.sv - shared definitions for the pooling layer sequencer
// Contents: sequencer state encoding (ST_IDLE, ST_STREAM, ST_DRAIN, ST_DONE)
//           and the PERIOD clock-period macro used by the benches.
`ifndef PERIOD
`define PERIOD 10
`endif

package definitions;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_t;
endpackage

// File: rtl/pooling_layer_sequencer_skid_buffer.sv
// rtl/pooling_layer_sequencer_skid_buffer.sv - 2-entry skid buffer for pooled pixels
// Ports: clk, rst_n (async active-low), enq/enq_data (write side),
//        deq (read side, ignored when empty), free_count (free entries after
//        this cycle's dequeue), out_valid/out_data (registered head entry).
module pool_skid_buffer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [1:0]       free_count,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  logic             v1;
  logic [WIDTH-1:0] mem1;
  logic             deq_ok;

  assign deq_ok     = deq && out_valid;
  // Counting the dequeue as space lets a full buffer accept while draining.
  assign free_count = 2'd2 - {1'b0, out_valid} - {1'b0, v1} + {1'b0, deq_ok};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      v1        <= 1'b0;
      out_data  <= '0;
      mem1      <= '0;
    end else if (deq_ok) begin
      if (v1) begin
        out_data <= mem1;
        if (enq) mem1 <= enq_data;
        else     v1   <= 1'b0;
      end else if (enq) begin
        out_data <= enq_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (enq) begin
      // Head is only written when empty, so it holds steady under backpressure.
      if (!out_valid) begin
        out_data  <= enq_data;
        out_valid <= 1'b1;
      end else if (!v1) begin
        mem1 <= enq_data;
        v1   <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/pooling_layer_sequencer.sv
// rtl/pooling_layer_sequencer.sv - frame-level controller for pooling_layer
// Ports: clk, rst_n (async active-low), start pulse; src_data/src_valid/src_ready
//        upstream pixels; pool_clk_en/pool_data drive the pooling layer and
//        pool_out_data/pool_valid return its results; dst_data/dst_valid/dst_ready
//        downstream via a skid buffer; busy, frame_done pulse, sticky count_error.
// Option: define POOL_SEQ_PERF_EN to add the 32-bit stall_cycles counter output.
module pooling_layer_sequencer
  import definitions::*;
#(
  parameter int D_WIDTH       = 8,
  parameter int CHANNELS      = 3,
  parameter int IMAGE_WIDTH   = 64,
  parameter int IMAGE_HEIGHT  = 32,
  parameter int STRIDE        = 2,
  parameter int FLUSH_CYCLES  = 4,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [D_WIDTH*CHANNELS-1:0] src_data,
  input  logic                        src_valid,
  output logic                        src_ready,
  output logic                        pool_clk_en,
  output logic [D_WIDTH*CHANNELS-1:0] pool_data,
  input  logic [D_WIDTH*CHANNELS-1:0] pool_out_data,
  input  logic                        pool_valid,
  output logic [D_WIDTH*CHANNELS-1:0] dst_data,
  output logic                        dst_valid,
  input  logic                        dst_ready,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        count_error
`ifdef POOL_SEQ_PERF_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);
  localparam int PW       = D_WIDTH * CHANNELS;
  localparam int TOTAL_IN = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int EXP_OUT  = TOTAL_IN / (STRIDE * STRIDE);
  localparam int IN_W     = $clog2(TOTAL_IN + 1);
  localparam int OUT_W    = $clog2(EXP_OUT + 1);
  localparam int FL_W     = $clog2(FLUSH_CYCLES + 1);
  localparam int TO_W     = $clog2(DRAIN_TIMEOUT + 1);

  seq_state_t       state;
  logic [IN_W-1:0]  in_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic [FL_W-1:0]  flush_cnt;
  logic [TO_W-1:0]  drain_cnt;
  logic [1:0]       skid_free;
  logic             space, enq, pv_err;

  assign space  = (skid_free != 2'd0);
  assign enq    = pool_valid && space;
  // A result beyond the expected count, or one with nowhere to go, is an error.
  assign pv_err = pool_valid && (!space || (out_cnt == OUT_W'(EXP_OUT)));

  always_comb begin
    src_ready   = 1'b0;
    pool_clk_en = 1'b0;
    pool_data   = '0;
    case (state)
      ST_STREAM: begin
        pool_clk_en = src_valid && space;
        src_ready   = pool_clk_en;
        pool_data   = src_data;
      end
      ST_DRAIN: pool_clk_en = space && (flush_cnt != FL_W'(FLUSH_CYCLES));
      default: ;
    endcase
  end

  pool_skid_buffer #(.WIDTH(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq       (enq),
    .enq_data  (pool_out_data),
    .deq       (dst_ready),
    .free_count(skid_free),
    .out_valid (dst_valid),
    .out_data  (dst_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      flush_cnt   <= '0;
      drain_cnt   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      count_error <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (enq && out_cnt != OUT_W'(EXP_OUT)) out_cnt <= out_cnt + 1'b1;
      if (pv_err) count_error <= 1'b1;
      case (state)
        ST_IDLE: begin
          // Clears placed after the pool_valid updates so they take priority.
          if (start) begin
            state       <= ST_STREAM;
            busy        <= 1'b1;
            in_cnt      <= '0;
            out_cnt     <= '0;
            count_error <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (src_valid && src_ready) begin
            if (in_cnt != IN_W'(TOTAL_IN)) in_cnt <= in_cnt + 1'b1;
            if (in_cnt == IN_W'(TOTAL_IN - 1)) begin
              state     <= ST_DRAIN;
              flush_cnt <= '0;
              drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (pool_clk_en) flush_cnt <= flush_cnt + 1'b1;
          if (drain_cnt != TO_W'(DRAIN_TIMEOUT)) drain_cnt <= drain_cnt + 1'b1;
          if (out_cnt == OUT_W'(EXP_OUT) && !dst_valid) begin
            state      <= ST_DONE;
            frame_done <= !(count_error || pv_err);
          end else if (drain_cnt == TO_W'(DRAIN_TIMEOUT - 1)) begin
            state       <= ST_DONE;
            count_error <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef POOL_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (state == ST_IDLE && start)
      stall_cycles <= '0;
    else if (state == ST_STREAM && src_valid && !pool_clk_en)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_pooling_layer_sequencer.sv
// tb/tb_pooling_layer_sequencer.sv - self-checking bench for pooling_layer_sequencer
`ifndef PERIOD
`define PERIOD 10
`endif

module tb_pooling_layer_sequencer;
  localparam int PW   = 24;
  localparam int W    = 64;
  localparam int H    = 32;
  localparam int NPIX = W * H;
  localparam int NOUT = NPIX / 4;

  logic          clk, rst_n, start;
  logic [PW-1:0] src_data, pool_data, pool_out_data, dst_data;
  logic          src_valid, src_ready, pool_clk_en, pool_valid;
  logic          dst_valid, dst_ready, busy, frame_done, count_error;
`ifdef POOL_SEQ_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  pooling_layer_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .pool_clk_en  (pool_clk_en),
    .pool_data    (pool_data),
    .pool_out_data(pool_out_data),
    .pool_valid   (pool_valid),
    .dst_data     (dst_data),
    .dst_valid    (dst_valid),
    .dst_ready    (dst_ready),
    .busy         (busy),
    .frame_done   (frame_done),
    .count_error  (count_error)
`ifdef POOL_SEQ_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #(`PERIOD / 2) clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [PW-1:0] chmax(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] r;
    for (int k = 0; k < 3; k++) r[k*8 +: 8] = (a[k*8 +: 8] > b[k*8 +: 8]) ? a[k*8 +: 8] : b[k*8 +: 8];
    return r;
  endfunction

  logic [PW-1:0] frame [NPIX];
  logic [PW-1:0] exp_px [NOUT];
  bit            drop_last;
  int            cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in pooling layer: streaming 2x2 max pool, two enabled stages deep,
  // result presented alongside the enable that retires it.
  logic [PW-1:0] hold, s0_d, s1_d;
  logic [PW-1:0] lbuf [W/2];
  logic          s0_v, s1_v, s0_last, s1_last;
  int            spx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spx <= 0; s0_v <= 1'b0; s1_v <= 1'b0; s0_last <= 1'b0; s1_last <= 1'b0;
    end else if (start) begin
      spx <= 0; s0_v <= 1'b0; s1_v <= 1'b0; s0_last <= 1'b0; s1_last <= 1'b0;
    end else if (pool_clk_en) begin
      spx     <= spx + 1;
      s1_v    <= s0_v;
      s1_d    <= s0_d;
      s1_last <= s0_last;
      s0_v    <= 1'b0;
      s0_last <= 1'b0;
      if (spx < NPIX) begin
        if (spx % 2 == 0) hold <= pool_data;
        else if ((spx / W) % 2 == 0) lbuf[(spx % W) / 2] <= chmax(hold, pool_data);
        else begin
          s0_v    <= 1'b1;
          s0_d    <= chmax(lbuf[(spx % W) / 2], chmax(hold, pool_data));
          s0_last <= (spx == NPIX - 1);
        end
      end
    end
  end

  assign pool_valid    = pool_clk_en && s1_v && !(drop_last && s1_last);
  assign pool_out_data = s1_d;

  // Scoreboard and invariant monitor, sampled on the falling edge.
  int            occ, out_idx, done_cnt, acc_cnt, exp_stall, last_hs_cyc;
  bit            prev_stall;
  logic [PW-1:0] prev_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      occ        <= 0;
      prev_stall <= 1'b0;
    end else begin
      check_eq("dst_valid_vs_occupancy", {31'b0, dst_valid}, {31'b0, occ != 0});
      if (prev_stall) check_eq("dst_data_hold", dst_data, prev_data);
      if (occ == 2 && !(dst_valid && dst_ready)) check_eq("clk_en_when_full", {31'b0, pool_clk_en}, 0);
      if (busy && acc_cnt < NPIX && !src_valid) check_eq("clk_en_without_src", {31'b0, pool_clk_en}, 0);
      if (busy && acc_cnt < NPIX && src_valid && occ == 2 && !(dst_valid && dst_ready))
        exp_stall <= exp_stall + 1;
      if (dst_valid && dst_ready) begin
        if (out_idx < NOUT) check_eq("dst_data", dst_data, exp_px[out_idx]);
        else check_eq("extra_output", out_idx, NOUT - 1);
        out_idx     <= out_idx + 1;
        last_hs_cyc <= cyc;
      end
      if (frame_done) begin
        done_cnt <= done_cnt + 1;
        check_eq("done_after_last_handshake", {31'b0, cyc > last_hs_cyc}, 1);
      end
      if (src_valid && src_ready) acc_cnt <= acc_cnt + 1;
      occ        <= occ + int'(pool_valid) - int'(dst_valid && dst_ready);
      prev_stall <= dst_valid && !dst_ready;
      prev_data  <= dst_data;
      if (start && !busy) begin
        out_idx   <= 0;
        done_cnt  <= 0;
        acc_cnt   <= 0;
        exp_stall <= 0;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_src_ready"},   {31'b0, src_ready}, 0);
    check_eq({tag, "_pool_clk_en"}, {31'b0, pool_clk_en}, 0);
    check_eq({tag, "_pool_data"},   pool_data, 0);
    check_eq({tag, "_dst_valid"},   {31'b0, dst_valid}, 0);
    check_eq({tag, "_dst_data"},    dst_data, 0);
    check_eq({tag, "_busy"},        {31'b0, busy}, 0);
    check_eq({tag, "_frame_done"},  {31'b0, frame_done}, 0);
    check_eq({tag, "_count_error"}, {31'b0, count_error}, 0);
  endtask

  // rmode: 0 ready always, 1 ready one cycle in three, 2 ready low for a window.
  task automatic run_frame(input int vpct, input int rmode, input bit drop,
                           input int abort_px, input int low_first);
    int px, c;
    logic [7:0] m;
    for (int i = 0; i < NPIX; i++) frame[i] = PW'($urandom);
    for (int y = 0; y < H / 2; y++)
      for (int x = 0; x < W / 2; x++)
        for (int k = 0; k < 3; k++) begin
          m = 8'd0;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
              if (frame[(2*y+dy)*W + 2*x+dx][k*8 +: 8] > m) m = frame[(2*y+dy)*W + 2*x+dx][k*8 +: 8];
          exp_px[y*(W/2) + x][k*8 +: 8] = m;
        end
    drop_last = drop;
    @(posedge clk); #1;
    start = 1'b1; src_valid = 1'b0; dst_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", {31'b0, busy}, 1);
    px = 0;
    c  = 0;
    while (c < 20000) begin
      src_valid = (px < NPIX) && (c >= low_first) && ($urandom_range(99) < vpct);
      if (px < NPIX) src_data = frame[px];
      else src_data = PW'($urandom);
      case (rmode)
        0:       dst_ready = 1'b1;
        1:       dst_ready = (c % 3 == 0);
        default: dst_ready = !(c >= 30 && c < 40);
      endcase
      @(negedge clk);
      if (src_valid && src_ready) px++;
      if (!busy) break;
      if (abort_px >= 0 && px == abort_px) begin
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(posedge clk); #1;
        src_valid = 1'b0;
        rst_n     = 1'b1;
        return;
      end
      @(posedge clk); #1;
      c++;
    end
    check_eq("frame_within_budget", {31'b0, c < 20000}, 1);
    src_valid = 1'b0;
    dst_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("busy_after_frame", {31'b0, busy}, 0);
    check_eq("output_count", out_idx, drop ? NOUT - 1 : NOUT);
    check_eq("frame_done_count", done_cnt, drop ? 0 : 1);
    check_eq("count_error", {31'b0, count_error}, {31'b0, drop});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src_valid = 1'b0; src_data = '0;
    dst_ready = 1'b1; drop_last = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(100, 0, 1'b0, -1, 0);
    run_frame(100, 1, 1'b0, -1, 0);
    run_frame(50,  0, 1'b0, -1, 0);
    run_frame(100, 0, 1'b1, -1, 0);
    run_frame(100, 0, 1'b0, 1000, 0);
    run_frame(100, 0, 1'b0, -1, 0);
`ifdef POOL_SEQ_PERF_EN
    run_frame(100, 0, 1'b0, -1, 10);
    check_eq("stall_cycles_idle_src", stall_cycles, 0);
    run_frame(100, 2, 1'b0, -1, 0);
    check_eq("stall_cycles_full_skid", stall_cycles, exp_stall);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(`PERIOD * 90000);
    $display("FAIL watchdog: simulation exceeded cycle limit");
    $fatal(1, "watchdog");
  end
endmodule
